// File: rtl/cc_matrix_pkg.sv
// Shared constants for the MAX7219 matrix transmitter: register addresses,
// configuration words and the state encodings of the sequencer and shifter.
package cc_matrix_pkg;

   localparam logic [7:0] ADDR_DIGIT0    = 8'h01;
   localparam logic [7:0] ADDR_DIGIT1    = 8'h02;
   localparam logic [7:0] ADDR_DIGIT2    = 8'h03;
   localparam logic [7:0] ADDR_DIGIT3    = 8'h04;
   localparam logic [7:0] ADDR_DIGIT4    = 8'h05;
   localparam logic [7:0] ADDR_DIGIT5    = 8'h06;
   localparam logic [7:0] ADDR_DIGIT6    = 8'h07;
   localparam logic [7:0] ADDR_DIGIT7    = 8'h08;
   localparam logic [7:0] ADDR_DECODE    = 8'h09;
   localparam logic [7:0] ADDR_INTENSITY = 8'h0A;
   localparam logic [7:0] ADDR_SCANLIMIT = 8'h0B;
   localparam logic [7:0] ADDR_SHUTDOWN  = 8'h0C;
   localparam logic [7:0] ADDR_TEST      = 8'h0F;

   localparam logic [15:0] CFG_TEST_OFF       = {ADDR_TEST,      8'h00};
   localparam logic [15:0] CFG_SCAN_LIMIT     = {ADDR_SCANLIMIT, 8'h07};
   localparam logic [15:0] CFG_NO_DECODE      = {ADDR_DECODE,    8'h00};
   localparam logic [15:0] CFG_INTENSITY_BASE = {ADDR_INTENSITY, 8'h00};
   localparam logic [15:0] CFG_NORMAL_OP      = {ADDR_SHUTDOWN,  8'h01};

   localparam logic [3:0] IDX_CFG_LAST  = 4'd4;
   localparam logic [3:0] IDX_ROW_FIRST = 4'd5;
   localparam logic [3:0] IDX_ROW_LAST  = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOADW,
      ST_SHIFT,
      ST_LATCH
   } tx_state_e;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_LOW,
      PH_HIGH,
      PH_GAP0,
      PH_GAP1
   } sh_phase_e;

   function automatic logic [15:0] intensity_word(input logic [3:0] level);
      return CFG_INTENSITY_BASE | {12'h000, level};
   endfunction

   function automatic logic [7:0] digit_addr(input logic [2:0] row);
      logic [7:0] addr;
      case (row)
         3'd0:    addr = ADDR_DIGIT0;
         3'd1:    addr = ADDR_DIGIT1;
         3'd2:    addr = ADDR_DIGIT2;
         3'd3:    addr = ADDR_DIGIT3;
         3'd4:    addr = ADDR_DIGIT4;
         3'd5:    addr = ADDR_DIGIT5;
         3'd6:    addr = ADDR_DIGIT6;
         default: addr = ADDR_DIGIT7;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/cc_max7219_shifter.sv
// 16-bit MSB-first serializer with SCLK divider and LOAD framing; a start
// accepted while ready drops LOAD and presents bit 15 on the next cycle.
//
// phase   | meaning
// PH_IDLE | nothing to send, LOAD high
// PH_LOW  | SCLK low half of a bit, DIN updated on entry
// PH_HIGH | SCLK high half of a bit, DIN held
// PH_GAP0 | first half of the LOAD-high latch gap
// PH_GAP1 | second half of the latch gap, next word may start at its end
module cc_max7219_shifter
   import cc_matrix_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk_sys,
   input  logic        rst_b,
   input  logic        start,
   input  logic [15:0] word,
   output logic        ready,
   output logic        word_end,
   output logic        done,
   output logic        din,
   output logic        sclk,
   output logic        load
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   sh_phase_e   phase_q, phase_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  bit_q, bit_d;
   logic [15:0] sr_q, sr_d;
   logic        din_q, din_d;
   logic        sclk_q, sclk_d;
   logic        load_q, load_d;
   logic        done_q, done_d;
   logic        div_last;

   assign div_last = (div_q == DIV_LAST);
   assign ready    = (phase_q == PH_IDLE) || ((phase_q == PH_GAP1) && div_last);
   assign word_end = (phase_q == PH_HIGH) && div_last && (bit_q == 4'd0);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         phase_q <= PH_IDLE;
         div_q   <= 8'd0;
         bit_q   <= 4'd0;
         sr_q    <= 16'h0000;
         din_q   <= 1'b0;
         sclk_q  <= 1'b0;
         load_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         din_q   <= din_d;
         sclk_q  <= sclk_d;
         load_q  <= load_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      din_d   = din_q;
      sclk_d  = sclk_q;
      load_d  = load_q;
      done_d  = 1'b0;
      if (ready && start) begin
         phase_d = PH_LOW;
         div_d   = 8'd0;
         bit_d   = 4'd15;
         sr_d    = word;
         din_d   = word[15];
         sclk_d  = 1'b0;
         load_d  = 1'b0;
      end else begin
         case (phase_q)
            PH_LOW: begin
               if (div_last) begin
                  div_d   = 8'd0;
                  sclk_d  = 1'b1;
                  phase_d = PH_HIGH;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            PH_HIGH: begin
               if (div_last) begin
                  div_d  = 8'd0;
                  sclk_d = 1'b0;
                  if (bit_q == 4'd0) begin
                     phase_d = PH_GAP0;
                     load_d  = 1'b1;
                     din_d   = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     // shift register keeps the next bit at position 14
                     bit_d   = bit_q - 4'd1;
                     sr_d    = {sr_q[14:0], 1'b0};
                     din_d   = sr_q[14];
                     phase_d = PH_LOW;
                  end
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            PH_GAP0: begin
               if (div_last) begin
                  div_d   = 8'd0;
                  phase_d = PH_GAP1;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            PH_GAP1: begin
               if (div_last) begin
                  div_d   = 8'd0;
                  phase_d = PH_IDLE;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign din  = din_q;
   assign sclk = sclk_q;
   assign load = load_q;
   assign done = done_q;

endmodule

// File: rtl/cc_matrix_max7219_tx.sv
// MAX7219 matrix transmitter: five configuration words after reset, then an
// endless refresh of eight row words taken from a per-frame row snapshot.
//
// state    | meaning
// ST_IDLE  | single cycle after reset release, first word is started
// ST_LOADW | first shift cycle of a freshly loaded word
// ST_SHIFT | remaining bits of the word are shifted out
// ST_LATCH | LOAD-high gap, next word started at its end
module cc_matrix_max7219_tx
   import cc_matrix_pkg::*;
#(
   parameter int         CLK_DIV   = 4,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic       CC_MATRIXTX_CLOCK_50,
   input  logic       CC_MATRIXTX_RESET_InLow,
   input  logic [7:0] CC_MATRIXTX_ROW_0,
   input  logic [7:0] CC_MATRIXTX_ROW_1,
   input  logic [7:0] CC_MATRIXTX_ROW_2,
   input  logic [7:0] CC_MATRIXTX_ROW_3,
   input  logic [7:0] CC_MATRIXTX_ROW_4,
   input  logic [7:0] CC_MATRIXTX_ROW_5,
   input  logic [7:0] CC_MATRIXTX_ROW_6,
   input  logic [7:0] CC_MATRIXTX_ROW_7,
   output logic       CC_MATRIXTX_DIN,
   output logic       CC_MATRIXTX_SCLK,
   output logic       CC_MATRIXTX_LOAD,
   output logic       CC_MATRIXTX_INITDONE,
   output logic       CC_MATRIXTX_FRAMEDONE
);

   logic        clk_sys;
   logic        rst_b;
   logic [7:0]  rows   [8];
   logic [7:0]  snap_q [8];
   logic [3:0]  idx_q;
   logic [2:0]  row_sel;
   logic [15:0] word;
   logic        start;
   logic        ready;
   logic        word_end;
   logic        done;
   logic        init_q;
   logic        frame_q;
   tx_state_e   state_q, state_d;

   assign clk_sys = CC_MATRIXTX_CLOCK_50;
   assign rst_b   = CC_MATRIXTX_RESET_InLow;
   assign rows[0] = CC_MATRIXTX_ROW_0;
   assign rows[1] = CC_MATRIXTX_ROW_1;
   assign rows[2] = CC_MATRIXTX_ROW_2;
   assign rows[3] = CC_MATRIXTX_ROW_3;
   assign rows[4] = CC_MATRIXTX_ROW_4;
   assign rows[5] = CC_MATRIXTX_ROW_5;
   assign rows[6] = CC_MATRIXTX_ROW_6;
   assign rows[7] = CC_MATRIXTX_ROW_7;

   // Row 0 goes out in the same cycle the snapshot is taken, so it is read live.
   always_comb begin
      row_sel = 3'(idx_q - IDX_ROW_FIRST);
      case (idx_q)
         4'd0:    word = CFG_TEST_OFF;
         4'd1:    word = CFG_SCAN_LIMIT;
         4'd2:    word = CFG_NO_DECODE;
         4'd3:    word = intensity_word(INTENSITY);
         4'd4:    word = CFG_NORMAL_OP;
         default: word = {digit_addr(row_sel),
                          (idx_q == IDX_ROW_FIRST) ? rows[0] : snap_q[row_sel]};
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            start   = 1'b1;
            state_d = ST_LOADW;
         end
         ST_LOADW: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (word_end) begin
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            if (ready) begin
               start   = 1'b1;
               state_d = ST_LOADW;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         idx_q   <= 4'd0;
         init_q  <= 1'b0;
         frame_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            snap_q[i] <= 8'h00;
         end
      end else begin
         if (start && (idx_q == IDX_ROW_FIRST)) begin
            for (int i = 0; i < 8; i++) begin
               snap_q[i] <= rows[i];
            end
         end
         if (done) begin
            idx_q <= (idx_q == IDX_ROW_LAST) ? IDX_ROW_FIRST : idx_q + 4'd1;
         end
         // word_end is the cycle before LOAD rises, so both flags line up with it
         init_q  <= init_q | (word_end && (idx_q == IDX_CFG_LAST));
         frame_q <= word_end && (idx_q == IDX_ROW_LAST);
      end
   end

   cc_max7219_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk_sys  (clk_sys),
      .rst_b    (rst_b),
      .start    (start),
      .word     (word),
      .ready    (ready),
      .word_end (word_end),
      .done     (done),
      .din      (CC_MATRIXTX_DIN),
      .sclk     (CC_MATRIXTX_SCLK),
      .load     (CC_MATRIXTX_LOAD)
   );

   assign CC_MATRIXTX_INITDONE  = init_q;
   assign CC_MATRIXTX_FRAMEDONE = frame_q;

endmodule

// File: doc/cc_matrix_max7219_tx.md
# cc_matrix_max7219_tx

Serial transmitter that takes the eight 8-bit row bytes produced by the screen-selection logic (game, win or lose frame) and drives a MAX7219-style 8x8 LED matrix driver over its 3-wire serial link.
- After reset it sends a fixed five-word configuration sequence.
- It then refreshes the display continuously, one 16-bit word per row.
- Each refresh works from a coherent snapshot of the row inputs.
- It sits between the screen comparator and the board pins.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 1..255.
- INTENSITY, 4'h8: value sent to the intensity register.

Ports:
- CC_MATRIXTX_CLOCK_50  in  1  system clock; all logic is on its rising edge.
- CC_MATRIXTX_RESET_InLow  in  1  reset, asynchronous and active-low.
- CC_MATRIXTX_ROW_0 .. CC_MATRIXTX_ROW_7  in  8 each  row bytes; ROW_k is displayed on matrix digit k+1.
- CC_MATRIXTX_DIN  out  1  serial data, MSB first.
- CC_MATRIXTX_SCLK  out  1  serial clock; idles low.
- CC_MATRIXTX_LOAD  out  1  word frame; low while shifting, rising edge latches the word; idles high.
- CC_MATRIXTX_INITDONE  out  1  level; set when the last configuration word is latched.
- CC_MATRIXTX_FRAMEDONE  out  1  one-cycle pulse when the row-8 word is latched.

## Operation
- Reset values: DIN=0, SCLK=0, LOAD=1, INITDONE=0, FRAMEDONE=0. Word index=0, snapshot=0.
- Word index 0..12 selects the word to send.
- Configuration words, index 0..4: 0x0F00 (test off), 0x0B07 (scan limit 8), 0x0900 (no decode), 0x0A0 concatenated with INTENSITY, 0x0C01 (normal operation).
- Row words, index 5..12: address (index-4) in bits 15:8 and snapshot row (index-5) in bits 7:0.
- Snapshot: all eight ROW inputs are registered in the cycle a word with index 5 is loaded. Row changes made mid-frame do not appear until the next frame.
- After index 12 the index returns to 5. Refresh then continues forever with no idle gap.
- States:
  - IDLE: one cycle after reset release.
  - LOADW: build the 16-bit word; take the snapshot if index=5.
  - SHIFT: 16 bits.
  - LATCH: LOAD-high gap.
  - Transitions: IDLE->LOADW->SHIFT->LATCH->LOADW.
- Counters:
  - Divider counts 0..CLK_DIV-1.
  - Bit counter counts 15 down to 0.
  - The divider wraps to 0 at each phase change. No other wrap-around is permitted.
- INITDONE sets when index 4 is latched. It stays set until reset.
- Reset mid-word: outputs return to their reset values immediately (asynchronous). The whole configuration sequence restarts.

## Timing
- The LOADW cycle is folded into the first SHIFT cycle.
  - First LOAD fall: 1 cycle after reset release, i.e. the cycle after IDLE.
  - DIN = bit 15 in that same cycle.
- Each bit:
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DIN changes only on the cycle SCLK goes low.
  - DIN is stable for the whole high phase.
- After the high phase of bit 0, in a single cycle: SCLK goes low, LOAD rises, DIN goes to 0.
- LOAD stays high for 2*CLK_DIV cycles (LATCH). LOAD then falls for the next word.
- Word period is exactly 34*CLK_DIV cycles.
- Frame period is 272*CLK_DIV cycles.
- The configuration sequence takes 170*CLK_DIV cycles.
- FRAMEDONE is high for exactly the single cycle in which LOAD rises for index 12.
- INITDONE rises in the cycle in which LOAD rises for index 4.

## Structure
- Shared package cc_matrix_pkg contains:
  - register address constants: DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST;
  - the five configuration word values;
  - the state encoding.
- One sub-module, cc_max7219_shifter:
  - contains the 16-bit serializer and the divider;
  - start/word inputs; done pulse at LOAD rise;
  - drives DIN, SCLK and LOAD.
- The top level holds the word-index sequencer, the snapshot registers and INITDONE/FRAMEDONE.

## Test plan
- Reset values: hold reset low with random rows -> DIN=0, SCLK=0, LOAD=1, flags 0. Release reset -> LOAD falls exactly 1 cycle later.
- Configuration sequence: a bench model captures 16 bits on each SCLK rise and checks each word at LOAD rise.
  - Words must be 0x0F00, 0x0B07, 0x0900, 0x0A08, 0x0C01, in that order.
  - INITDONE rises with the 5th LOAD rise.
- Row frame: ROW_0..7 = 0x81, 0x42, 0x24, 0x18, 0x18, 0x24, 0x42, 0x81.
  - Expected words: 0x0181, 0x0242, ..., 0x0881.
  - Then 0x0181 again.
  - FRAMEDONE is exactly one pulse per frame.
- Snapshot coherence: change ROW_0 from 0x81 to 0xFF during the word with address 3.
  - The rest of the current frame is unchanged.
  - The next frame begins 0x01FF.
- Timing with CLK_DIV=1 and CLK_DIV=4: measure SCLK half-periods (1/4 cycles), the LOAD-high gap (2/8 cycles) and the word period (34/136 cycles).
- Reset mid-word: assert reset during bit 7 of word 0x0342.
  - LOAD=1 and SCLK=0 in the same cycle.
  - After release, the next captured word is 0x0F00.
